// File: rtl/toi2s_pkg.sv
// Shared types and constants for the amplifier-side sequencer.
// Holds the FSM encoding and the amplifier init write table.
package toi2s_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PWRUP = 3'd1,
    INIT  = 3'd2,
    MUTED = 3'd3,
    PLAY  = 3'd4,
    FAULT = 3'd5
  } amp_state_t;

  typedef struct packed {
    logic [7:0] reg_idx;
    logic [7:0] data;
  } init_entry_t;

  localparam int N_INIT = 3;
  localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1;

  localparam init_entry_t INIT_TABLE [N_INIT] = '{
    '{reg_idx: 8'h00, data: 8'h01},
    '{reg_idx: 8'h01, data: 8'h80},
    '{reg_idx: 8'h02, data: 8'h10}
  };

  localparam logic [7:0] AMP_VOL_REG = 8'h07;

endpackage

// File: rtl/amp_ctrl_seq.sv
// Amplifier power-up, init, mute and volume sequencer.
// Issues one I2C write at a time and retries on nack.
module amp_ctrl_seq
  import toi2s_pkg::*;
#(
  parameter logic [6:0] AMP_ADDR     = 7'h2C,
  parameter int         T_EN_CYC     = 4096,
  parameter int         T_UNMUTE_CYC = 65536,
  parameter int         MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       lock,
  input  logic       force_mute,
  input  logic       vol_req,
  input  logic [7:0] vol_val,
  output logic       i2cm_req,
  output logic [6:0] i2cm_addr,
  output logic [7:0] i2cm_reg,
  output logic [7:0] i2cm_data,
  input  logic       i2cm_done,
  input  logic       i2cm_nack,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       fault,
  output logic [2:0] state
);

  localparam int T_MAX = (T_EN_CYC > T_UNMUTE_CYC) ?
                         T_EN_CYC : T_UNMUTE_CYC;
  localparam int TW = $clog2(T_MAX) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;

  localparam logic [TW-1:0]    T_EN_LAST = TW'(T_EN_CYC - 1);
  localparam logic [TW-1:0]    T_UNMUTE  = TW'(T_UNMUTE_CYC);
  localparam logic [RW-1:0]    R_LAST    = RW'(MAX_RETRY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_INIT - 1);

  amp_state_t       st, st_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [RW-1:0]    rty, rty_nx;
  logic             retry, retry_nx;
  logic             vpend, vpend_nx;
  logic [7:0]       vbuf, vbuf_nx;
  logic             req_nx;
  logic [7:0]       reg_nx, data_nx;
  logic             nen_nx, nmute_nx, fault_nx;

  logic qual, txn_end, txn_ack, give_up, can_stop, run_st;

  assign qual     = lock & ~force_mute;
  assign txn_end  = i2cm_req & i2cm_done;
  assign txn_ack  = txn_end & ~i2cm_nack;
  assign give_up  = txn_end & i2cm_nack & (rty == R_LAST);
  assign can_stop = ~i2cm_req | i2cm_done;
  assign run_st   = (st == MUTED || st == PLAY) &&
                    (st_nx == MUTED || st_nx == PLAY);

  assign i2cm_addr = AMP_ADDR;
  assign state     = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= OFF;
      tmr         <= '0;
      idx         <= '0;
      rty         <= '0;
      retry       <= 1'b0;
      vpend       <= 1'b0;
      vbuf        <= '0;
      i2cm_req    <= 1'b0;
      i2cm_reg    <= '0;
      i2cm_data   <= '0;
      amp_nenable <= 1'b1;
      amp_nmute   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      st          <= st_nx;
      tmr         <= tmr_nx;
      idx         <= idx_nx;
      rty         <= rty_nx;
      retry       <= retry_nx;
      vpend       <= vpend_nx;
      vbuf        <= vbuf_nx;
      i2cm_req    <= req_nx;
      i2cm_reg    <= reg_nx;
      i2cm_data   <= data_nx;
      amp_nenable <= nen_nx;
      amp_nmute   <= nmute_nx;
      fault       <= fault_nx;
    end
  end

  // Dropping ena waits out an in-flight write before powering off.
  always_comb begin
    st_nx = st;
    unique case (st)
      OFF:
        if (ena) st_nx = PWRUP;
      PWRUP:
        if (!ena) st_nx = OFF;
        else if (tmr == T_EN_LAST) st_nx = INIT;
      INIT:
        if (!ena) begin
          if (can_stop) st_nx = OFF;
        end else if (give_up) st_nx = FAULT;
        else if (txn_ack && idx == IDX_LAST) st_nx = MUTED;
      MUTED:
        if (!ena) begin
          if (can_stop) st_nx = OFF;
        end else if (give_up) st_nx = FAULT;
        else if (qual && tmr >= T_UNMUTE) st_nx = PLAY;
      PLAY:
        if (!ena) begin
          if (can_stop) st_nx = OFF;
        end else if (give_up) st_nx = FAULT;
        else if (!qual) st_nx = MUTED;
      FAULT:
        if (!ena) st_nx = OFF;
      default:
        st_nx = OFF;
    endcase
  end

  always_comb begin
    tmr_nx   = '0;
    idx_nx   = (st == INIT) ? idx : '0;
    rty_nx   = rty;
    retry_nx = retry;
    req_nx   = i2cm_req;
    reg_nx   = i2cm_reg;
    data_nx  = i2cm_data;
    vpend_nx = vpend | vol_req;
    vbuf_nx  = vol_req ? vol_val : vbuf;

    if (txn_end) begin
      req_nx   = 1'b0;
      rty_nx   = i2cm_nack ? rty + RW'(1) : '0;
      retry_nx = i2cm_nack;
      if (st == INIT && !i2cm_nack && idx != IDX_LAST)
        idx_nx = idx + IDX_W'(1);
    end

    if (st == PWRUP && st_nx == PWRUP)
      tmr_nx = tmr + TW'(1);
    if (st == MUTED && st_nx == MUTED && qual)
      tmr_nx = (tmr >= T_UNMUTE) ? tmr : tmr + TW'(1);

    // A new write only starts on a cycle where req is already low.
    if (ena && !i2cm_req) begin
      if (st_nx == INIT) begin
        req_nx   = 1'b1;
        reg_nx   = INIT_TABLE[idx_nx].reg_idx;
        data_nx  = INIT_TABLE[idx_nx].data;
        retry_nx = 1'b0;
      end else if (run_st && retry) begin
        req_nx   = 1'b1;
        retry_nx = 1'b0;
      end else if (run_st && vpend) begin
        req_nx   = 1'b1;
        reg_nx   = AMP_VOL_REG;
        data_nx  = vbuf;
        vpend_nx = vol_req;
      end
    end

    if (st_nx == OFF || st_nx == FAULT) begin
      req_nx   = 1'b0;
      rty_nx   = '0;
      retry_nx = 1'b0;
    end
    if (st_nx == OFF && st != OFF)
      vpend_nx = 1'b0;

    nen_nx   = (st_nx == OFF) || (st_nx == FAULT);
    nmute_nx = (st_nx == PLAY) && ena;
    fault_nx = (st_nx == FAULT);
  end

endmodule

// File: tb/tb_amp_ctrl_seq.sv
// Directed bench for amp_ctrl_seq with a bench-driven I2C responder.
// Short timing parameters keep the power-up and unmute waits small.
module tb_amp_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena, lock, force_mute, vol_req;
  logic [7:0] vol_val;
  logic       i2cm_req;
  logic [6:0] i2cm_addr;
  logic [7:0] i2cm_reg, i2cm_data;
  logic       i2cm_done, i2cm_nack;
  logic       amp_nenable, amp_nmute, fault;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  amp_ctrl_seq #(
    .AMP_ADDR(7'h2C),
    .T_EN_CYC(16),
    .T_UNMUTE_CYC(32),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ena(ena),
    .lock(lock),
    .force_mute(force_mute),
    .vol_req(vol_req),
    .vol_val(vol_val),
    .i2cm_req(i2cm_req),
    .i2cm_addr(i2cm_addr),
    .i2cm_reg(i2cm_reg),
    .i2cm_data(i2cm_data),
    .i2cm_done(i2cm_done),
    .i2cm_nack(i2cm_nack),
    .amp_nenable(amp_nenable),
    .amp_nmute(amp_nmute),
    .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (i2cm_req !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic finish_txn(input bit nk);
    tick(2);
    i2cm_done = 1'b1;
    i2cm_nack = nk;
    tick();
    i2cm_done = 1'b0;
    i2cm_nack = 1'b0;
  endtask

  task automatic do_write(input bit nk, output logic [7:0] r,
                          output logic [7:0] d, output int cyc);
    wait_req(cyc);
    r = i2cm_reg;
    d = i2cm_data;
    finish_txn(nk);
  endtask

  task automatic count_unmute(output int cyc);
    cyc = 0;
    while (amp_nmute !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ena = 0; lock = 0; force_mute = 0;
    vol_req = 0; vol_val = 0;
    i2cm_done = 0; i2cm_nack = 0;
    tick(2);
    reset = 1'b0;
    tick();
    checks++;
    if (amp_nenable !== 1'b1) begin
      errors++;
      $display("FAIL rst_nenable: got %b want 1", amp_nenable);
    end
    checks++;
    if (amp_nmute !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_mute_fault: got %b%b want 00", amp_nmute, fault);
    end
    checks++;
    if (i2cm_req !== 1'b0 || i2cm_reg !== 8'h00 || i2cm_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_i2c: got %b %h %h want 0 00 00",
               i2cm_req, i2cm_reg, i2cm_data);
    end
    checks++;
    if (state !== 3'd0 || i2cm_addr !== 7'h2C) begin
      errors++;
      $display("FAIL rst_state_addr: got %0d %h want 0 2c", state, i2cm_addr);
    end
  endtask

  task automatic test_powerup_init;
    int cyc;
    logic [7:0] r, d;
    ena = 1'b1;
    tick();
    checks++;
    if (amp_nenable !== 1'b0 || state !== 3'd1) begin
      errors++;
      $display("FAIL pwrup_entry: got %b %0d want 0 1", amp_nenable, state);
    end
    wait_req(cyc);
    checks++;
    if (cyc != 16) begin
      errors++;
      $display("FAIL pwrup_delay: got %0d want 16", cyc);
    end
    checks++;
    if (i2cm_reg !== 8'h00 || i2cm_data !== 8'h01) begin
      errors++;
      $display("FAIL init0: got %h/%h want 00/01", i2cm_reg, i2cm_data);
    end
    finish_txn(0);
    checks++;
    if (i2cm_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: got %b want 0", i2cm_req);
    end
    do_write(0, r, d, cyc);
    checks++;
    if (cyc != 1 || r !== 8'h01 || d !== 8'h80) begin
      errors++;
      $display("FAIL init1: got gap %0d %h/%h want 1 01/80", cyc, r, d);
    end
    do_write(0, r, d, cyc);
    checks++;
    if (r !== 8'h02 || d !== 8'h10) begin
      errors++;
      $display("FAIL init2: got %h/%h want 02/10", r, d);
    end
    checks++;
    if (state !== 3'd3 || amp_nmute !== 1'b0) begin
      errors++;
      $display("FAIL init_done: got %0d %b want 3 0", state, amp_nmute);
    end
  endtask

  task automatic test_unmute;
    int cyc;
    lock = 1'b1;
    tick(20);
    lock = 1'b0;
    tick();
    checks++;
    if (amp_nmute !== 1'b0) begin
      errors++;
      $display("FAIL glitch_mute: got %b want 0", amp_nmute);
    end
    lock = 1'b1;
    count_unmute(cyc);
    checks++;
    if (cyc != 33 || state !== 3'd4) begin
      errors++;
      $display("FAIL unmute: got %0d edges st %0d want 33 st 4", cyc, state);
    end
    force_mute = 1'b1;
    tick();
    checks++;
    if (amp_nmute !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL force_mute: got %b %0d want 0 3", amp_nmute, state);
    end
    force_mute = 1'b0;
    count_unmute(cyc);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL re_unmute: got %0d want 33", cyc);
    end
  endtask

  task automatic test_vol_play;
    int cyc;
    vol_val = 8'h33;
    vol_req = 1'b1;
    tick();
    vol_req = 1'b0;
    wait_req(cyc);
    checks++;
    if (cyc > 5 || i2cm_reg !== 8'h07 || i2cm_data !== 8'h33) begin
      errors++;
      $display("FAIL vol_play: got %0d %h/%h want <=5 07/33",
               cyc, i2cm_reg, i2cm_data);
    end
    checks++;
    if (amp_nmute !== 1'b1) begin
      errors++;
      $display("FAIL vol_play_mute: got %b want 1", amp_nmute);
    end
    finish_txn(0);
    checks++;
    if (amp_nmute !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL vol_play_end: got %b %0d want 1 4", amp_nmute, state);
    end
  endtask

  task automatic test_retry;
    int cyc, n;
    logic [7:0] r, d;
    bit nk [3] = '{1'b1, 1'b1, 1'b0};
    lock = 1'b0;
    ena = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || amp_nenable !== 1'b1) begin
      errors++;
      $display("FAIL off: got %0d %b want 0 1", state, amp_nenable);
    end
    ena = 1'b1;
    do_write(0, r, d, cyc);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      do_write(nk[i], r, d, cyc);
      if (r === 8'h01) n++;
      if (i > 0) begin
        checks++;
        if (cyc != 1) begin
          errors++;
          $display("FAIL retry_gap: got %0d want 1", cyc);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL retry_count: got %0d want 3", n);
    end
    do_write(0, r, d, cyc);
    checks++;
    if (r !== 8'h02 || state !== 3'd3) begin
      errors++;
      $display("FAIL retry_done: got %h %0d want 02 3", r, state);
    end
    ena = 1'b0;
    tick();
    ena = 1'b1;
    for (int i = 0; i < 3; i++) do_write(1, r, d, cyc);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || amp_nenable !== 1'b1) begin
      errors++;
      $display("FAIL fault: got %0d %b %b want 5 1 1",
               state, fault, amp_nenable);
    end
    tick(5);
    checks++;
    if (i2cm_req !== 1'b0 || amp_nmute !== 1'b0 || state !== 3'd5) begin
      errors++;
      $display("FAIL fault_hold: got %b %b %0d want 0 0 5",
               i2cm_req, amp_nmute, state);
    end
    ena = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit: got %0d %b want 0 0", state, fault);
    end
  endtask

  task automatic test_vol_init;
    int cyc, n;
    logic [7:0] r, d;
    ena = 1'b1;
    wait_req(cyc);
    vol_val = 8'h40;
    vol_req = 1'b1;
    tick();
    vol_val = 8'h55;
    tick();
    vol_req = 1'b0;
    checks++;
    if (i2cm_reg !== 8'h00 || i2cm_data !== 8'h01) begin
      errors++;
      $display("FAIL vinit_hold: got %h/%h want 00/01", i2cm_reg, i2cm_data);
    end
    finish_txn(0);
    do_write(0, r, d, cyc);
    do_write(0, r, d, cyc);
    do_write(0, r, d, cyc);
    checks++;
    if (cyc != 1 || r !== 8'h07 || d !== 8'h55) begin
      errors++;
      $display("FAIL vinit_write: got %0d %h/%h want 1 07/55", cyc, r, d);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i2cm_req === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL vinit_extra: got %0d want 0", n);
    end
  endtask

  task automatic test_ena_off_inflight;
    int cyc;
    lock = 1'b1;
    count_unmute(cyc);
    vol_val = 8'h22;
    vol_req = 1'b1;
    tick();
    vol_req = 1'b0;
    wait_req(cyc);
    ena = 1'b0;
    tick();
    checks++;
    if (amp_nmute !== 1'b0 || i2cm_req !== 1'b1 || i2cm_data !== 8'h22) begin
      errors++;
      $display("FAIL off_mute: got %b %b %h want 0 1 22",
               amp_nmute, i2cm_req, i2cm_data);
    end
    tick(3);
    checks++;
    if (i2cm_req !== 1'b1 || amp_nenable !== 1'b0) begin
      errors++;
      $display("FAIL off_hold: got %b %b want 1 0", i2cm_req, amp_nenable);
    end
    i2cm_done = 1'b1;
    tick();
    i2cm_done = 1'b0;
    checks++;
    if (state !== 3'd0 || amp_nenable !== 1'b1 || i2cm_req !== 1'b0) begin
      errors++;
      $display("FAIL off_done: got %0d %b %b want 0 1 0",
               state, amp_nenable, i2cm_req);
    end
    lock = 1'b0;
  endtask

  task automatic test_async_reset;
    int cyc;
    ena = 1'b1;
    wait_req(cyc);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (i2cm_req !== 1'b0 || amp_nenable !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL areset: got %b %b %0d want 0 1 0",
               i2cm_req, amp_nenable, state);
    end
    checks++;
    if (i2cm_reg !== 8'h00 || i2cm_data !== 8'h00 ||
        amp_nmute !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL areset_regs: got %h %h %b %b want 00 00 0 0",
               i2cm_reg, i2cm_data, amp_nmute, fault);
    end
    tick();
    reset = 1'b0;
    ena = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_powerup_init();
    test_unmute();
    test_vol_play();
    test_retry();
    test_vol_init();
    test_ena_off_inflight();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amp_ctrl_seq.md
# amp_ctrl_seq

Power-up, configuration and mute sequencer for the external I2S amplifier. It sits between the register bank, the S/PDIF receiver lock flag and the amplifier-side I2C master. It drives `amp_nenable` and `amp_nmute` and issues the amplifier's init register writes and runtime volume writes through a single-transaction request/done handshake.

## Interface
Parameters:
- `AMP_ADDR`, default 7'h2C: 7-bit I2C address of the amplifier.
- `T_EN_CYC`, default 4096: clk cycles between deasserting `amp_nenable` and the first I2C write.
- `T_UNMUTE_CYC`, default 65536: clk cycles `lock` must stay high continuously before unmute.
- `MAX_RETRY`, default 3: attempts per I2C write before FAULT.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ena`  in  1  block enable; low sequences the amplifier off.
- `lock`  in  1  S/PDIF receiver locked.
- `force_mute`  in  1  register-bank mute override.
- `vol_req`  in  1  one-cycle pulse: write `vol_val` to the amp volume register.
- `vol_val`  in  8  volume value.
- `i2cm_req`  out  1  I2C write request to the master.
- `i2cm_addr`  out  7  device address; always `AMP_ADDR`.
- `i2cm_reg`  out  8  register index.
- `i2cm_data`  out  8  register data.
- `i2cm_done`  in  1  one-cycle pulse: transaction finished.
- `i2cm_nack`  in  1  valid only with `i2cm_done`; 1 means the write failed.
- `amp_nenable`  out  1  amplifier enable, active low.
- `amp_nmute`  out  1  amplifier mute, active low.
- `fault`  out  1  retries exhausted.
- `state`  out  3  current state, for `debug_out`.

## Operation
- All outputs are registered.
- Reset values: `amp_nenable`=1, `amp_nmute`=0, `i2cm_req`=0, `i2cm_reg`/`i2cm_data`=0, `fault`=0, `state`=OFF.
- States and transitions:
  - OFF: `amp_nenable`=1. Goes to PWRUP when `ena`=1.
  - PWRUP: `amp_nenable`=0. Counts `T_EN_CYC` cycles, then goes to INIT with the table index at 0.
  - INIT: issues `INIT_TABLE[idx]`. On done with no nack: increments idx; after the last entry (`N_INIT`-1), goes to MUTED.
  - MUTED: `amp_nmute`=0. Lock debounce counter runs while `lock`=1 and `force_mute`=0, and clears otherwise. When the counter reaches `T_UNMUTE_CYC`, goes to PLAY.
  - PLAY: `amp_nmute`=1. Goes to MUTED when `lock`=0 or `force_mute`=1; `amp_nmute` falls on the next edge.
  - FAULT: `amp_nenable`=1, `amp_nmute`=0, `fault`=1. Exits only when `ena`=0 (to OFF, `fault` cleared) or on reset.
- Volume writes: `vol_req` sets a one-entry pending buffer; a newer request overwrites an older one. The buffer is serviced in MUTED or PLAY when no transaction is active, as register `AMP_VOL_REG` with data `vol_val`. The mute state is not changed by a volume write. A pending request in OFF, PWRUP or INIT is kept until MUTED is reached.
- Retry: a nack re-issues the same write after one idle cycle. After `MAX_RETRY` failed attempts the block goes to FAULT.
- `ena`=0 mid-operation: `amp_nmute` goes 0 next cycle. An in-flight transaction is held until `i2cm_done`, then the block goes to OFF. Otherwise it goes to OFF immediately. The pending volume request is cleared.

## Timing
- Handshake: `i2cm_req` rises with `i2cm_reg`/`i2cm_data` stable. All three hold until the `i2cm_done` cycle. `i2cm_req` is low on the edge after done, and the next request is at least one cycle later.
- PWRUP to first `i2cm_req`: exactly `T_EN_CYC` cycles after `amp_nenable` falls.
- Unmute: `amp_nmute` rises `T_UNMUTE_CYC`+1 edges after the first cycle of continuous qualified lock.
- `lock` and `force_mute` are already synchronous to `clk`; no synchronizer inside this block.
- Counter widths: `$clog2` of the largest parameter plus 1. Counters saturate and never wrap.

## Structure
- `toi2s_pkg` holds:
  - `amp_state_t` enum: OFF, PWRUP, INIT, MUTED, PLAY, FAULT.
  - `init_entry_t` struct: reg, data.
  - `N_INIT` and `INIT_TABLE`.
  - `AMP_VOL_REG`.
- Single module with no sub-modules; the timer and the retry counter are inline. The I2C master is the existing amp-side master instantiated in the top level.

## Test plan
- Reset, then `ena`=1 with `T_EN_CYC`=16 and a 3-entry table, all acks → first `i2cm_req` 16 cycles after `amp_nenable`=0; three writes in order; `state`=MUTED; `amp_nmute`=0.
- `lock` held high with `T_UNMUTE_CYC`=32 → `amp_nmute`=1 after 33 edges. A `lock` glitch at cycle 20 restarts the count; `force_mute`=1 in PLAY → `amp_nmute`=0 next edge.
- Nack on init entry 1 twice, then ack → entry 1 is issued 3 times and the sequence completes. Nack 3 times → FAULT, `fault`=1, `amp_nenable`=1; `ena`=0 → OFF, `fault`=0.
- `vol_req` with 0x40, then 0x55, during INIT → exactly one volume write after init, with `AMP_VOL_REG`/0x55. `vol_req` in PLAY → write issued and `amp_nmute` stays 1.
- `ena`=0 while `i2cm_req`=1 → `amp_nmute`=0 next edge, `i2cm_req` held until `i2cm_done`, then OFF with `amp_nenable`=1.
- Assert `reset` asynchronously mid-INIT → all outputs at reset values before the next `clk` edge.
